apb_rule_demux: RTL and testbench

Parametrised APB demultiplexer between the core APB manager port and the peripheral subsystem (UART, mtimer, interrupt controller, spares). It decodes each transfer against a compile-time address-rule table and forwards it to one of `NrPorts` subordinate ports through a registered, fully APB-compliant setup/access sequence. Unmapped addresses return a local `PSLVERR`. An optional watchdog aborts transfers to subordinates that never assert `PREADY`. A sticky error-capture register records the first failing transfer.

---
 rtl/zeroheti_pkg.sv | 28 ++
 rtl/apb_demux_watchdog.sv | 38 +++
 rtl/apb_rule_demux.sv | 218 +++++++++++++++++++++
 tb/tb_apb_rule_demux.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zeroheti_pkg.sv
// zeroheti_pkg: APB demux address-rule type, default peripheral map and error-cause encoding.
package zeroheti_pkg;

   localparam int unsigned RuleAddrWidth   = 32;
   localparam int unsigned RuleIdxWidth    = 32;
   localparam int unsigned ApbDemuxNrPorts = 4;

   typedef struct packed {
      logic [RuleIdxWidth-1:0]  idx;
      logic [RuleAddrWidth-1:0] base;
      logic [RuleAddrWidth-1:0] last;
   } apb_rule_t;

   typedef enum logic [1:0] {
      NONE    = 2'b00,
      MISS    = 2'b01,
      TIMEOUT = 2'b10
   } err_cause_e;

   // Rule 3 overlaps rules 1-2; lower rules win, so port 3 only owns 0x0003_0200..0x0003_03ff.
   localparam apb_rule_t [ApbDemuxNrPorts-1:0] ApbDemuxMap = {
      apb_rule_t'{idx: 32'd3, base: 32'h0003_0000, last: 32'h0003_0400},
      apb_rule_t'{idx: 32'd2, base: 32'h0003_0100, last: 32'h0003_0200},
      apb_rule_t'{idx: 32'd1, base: 32'h0003_0000, last: 32'h0003_0100},
      apb_rule_t'{idx: 32'd0, base: 32'h0002_0000, last: 32'h0002_0100}
   };

endpackage

// File: rtl/apb_demux_watchdog.sv
// apb_demux_watchdog: saturating access-phase cycle counter with abort flag.
// Only present when APB_DEMUX_TIMEOUT_EN is defined.
`ifdef APB_DEMUX_TIMEOUT_EN
module apb_demux_watchdog #(
   parameter int unsigned TimeoutCycles = 256
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic cnt_en_i,
   output logic abort_c_o
);

   localparam int unsigned CntWidth = $clog2(TimeoutCycles + 1);

   logic [CntWidth-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (cnt_en_i && (cnt_q != CntWidth'(TimeoutCycles))) begin
         cnt_d = cnt_q + CntWidth'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign abort_c_o = cnt_en_i && (cnt_q == CntWidth'(TimeoutCycles - 1));

endmodule
`endif

// File: rtl/apb_rule_demux.sv
// apb_rule_demux: decodes an upstream APB transfer against AddrMap and replays it on one
// subordinate port. Define APB_DEMUX_TIMEOUT_EN to add the access-phase watchdog.
module apb_rule_demux
   import zeroheti_pkg::*;
#(
   parameter int unsigned             NrPorts       = 4,
   parameter int unsigned             AddrWidth     = 32,
   parameter int unsigned             DataWidth     = 32,
   parameter apb_rule_t [NrPorts-1:0] AddrMap       = ApbDemuxMap,
   parameter int unsigned             TimeoutCycles = 256
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         s_psel_i,
   input  logic                         s_penable_i,
   input  logic                         s_pwrite_i,
   input  logic [AddrWidth-1:0]         s_paddr_i,
   input  logic [DataWidth-1:0]         s_pwdata_i,
   output logic [DataWidth-1:0]         s_prdata_o,
   output logic                         s_pready_o,
   output logic                         s_pslverr_o,
   output logic [NrPorts-1:0]           m_psel_o,
   output logic                         m_penable_o,
   output logic                         m_pwrite_o,
   output logic [AddrWidth-1:0]         m_paddr_o,
   output logic [DataWidth-1:0]         m_pwdata_o,
   input  logic [NrPorts*DataWidth-1:0] m_prdata_i,
   input  logic [NrPorts-1:0]           m_pready_i,
   input  logic [NrPorts-1:0]           m_pslverr_i,
   input  logic                         err_clr_i,
   output logic                         err_valid_o,
   output logic [1:0]                   err_cause_o,
   output logic [AddrWidth-1:0]         err_addr_o
);

   localparam int unsigned IdxWidth = (NrPorts > 1) ? $clog2(NrPorts) : 1;

   if ((NrPorts < 1) || (NrPorts > 16) || (TimeoutCycles < 2)) begin : gen_bad_param
      $error("apb_rule_demux: NrPorts must be 1..16 and TimeoutCycles >= 2");
   end

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

   state_e                 state_q, state_d;
   logic [IdxWidth-1:0]    idx_q, idx_d;
   logic [AddrWidth-1:0]   paddr_q, paddr_d;
   logic [DataWidth-1:0]   pwdata_q, pwdata_d;
   logic                   pwrite_q, pwrite_d;
   logic [NrPorts-1:0]     psel_q, psel_d;
   logic                   penable_q, penable_d;
   logic                   pready_q, pready_d;
   logic [DataWidth-1:0]   prdata_q, prdata_d;
   logic                   pslverr_q, pslverr_d;
   logic                   err_valid_q, err_valid_d;
   err_cause_e             err_cause_q, err_cause_d;
   logic [AddrWidth-1:0]   err_addr_q, err_addr_d;

   logic                   hit_c;
   logic [IdxWidth-1:0]    hit_idx_c;
   logic                   timeout_c;
   logic                   err_set_c;
   err_cause_e             err_set_cause_c;
   logic [AddrWidth-1:0]   err_set_addr_c;

   // Walk rules from the top down so the lowest matching index is the one left standing.
   always_comb begin
      hit_c     = 1'b0;
      hit_idx_c = '0;
      for (int i = int'(NrPorts) - 1; i >= 0; i--) begin
         if ((s_paddr_i >= AddrWidth'(AddrMap[i].base)) &&
             (s_paddr_i <  AddrWidth'(AddrMap[i].last))) begin
            hit_c     = 1'b1;
            hit_idx_c = IdxWidth'(AddrMap[i].idx);
         end
      end
   end

`ifdef APB_DEMUX_TIMEOUT_EN
   apb_demux_watchdog #(
      .TimeoutCycles (TimeoutCycles)
   ) u_watchdog (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .clr_i     (state_q == SETUP),
      .cnt_en_i  (state_q == ACCESS),
      .abort_c_o (timeout_c)
   );
`else
   assign timeout_c = 1'b0;
`endif

   // Transfer sequencing; every output flop is loaded from its _d here.
   always_comb begin
      state_d         = state_q;
      idx_d           = idx_q;
      paddr_d         = paddr_q;
      pwdata_d        = pwdata_q;
      pwrite_d        = pwrite_q;
      pready_d        = 1'b0;
      prdata_d        = '0;
      pslverr_d       = 1'b0;
      psel_d          = '0;
      penable_d       = 1'b0;
      err_set_c       = 1'b0;
      err_set_cause_c = NONE;
      err_set_addr_c  = paddr_q;

      case (state_q)
         IDLE: begin
            if (s_psel_i && !s_penable_i) begin
               paddr_d  = s_paddr_i;
               pwdata_d = s_pwdata_i;
               pwrite_d = s_pwrite_i;
               if (hit_c) begin
                  idx_d   = hit_idx_c;
                  state_d = SETUP;
               end else begin
                  state_d         = RESP;
                  pready_d        = 1'b1;
                  pslverr_d       = 1'b1;
                  err_set_c       = 1'b1;
                  err_set_cause_c = MISS;
                  err_set_addr_c  = s_paddr_i;
               end
            end
         end
         SETUP: begin
            state_d = ACCESS;
         end
         ACCESS: begin
            if (m_pready_i[idx_q]) begin
               state_d   = RESP;
               pready_d  = 1'b1;
               prdata_d  = m_prdata_i[32'(idx_q) * DataWidth +: DataWidth];
               pslverr_d = m_pslverr_i[idx_q];
            end else if (timeout_c) begin
               state_d         = RESP;
               pready_d        = 1'b1;
               pslverr_d       = 1'b1;
               err_set_c       = 1'b1;
               err_set_cause_c = TIMEOUT;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if ((state_d == SETUP) || (state_d == ACCESS)) begin
         psel_d[idx_d] = 1'b1;
         penable_d     = (state_d == ACCESS);
      end
   end

   // Sticky first-error capture; a new error in the clearing cycle replaces the old one.
   always_comb begin
      err_valid_d = err_valid_q;
      err_cause_d = err_cause_q;
      err_addr_d  = err_addr_q;
      if (err_set_c && (!err_valid_q || err_clr_i)) begin
         err_valid_d = 1'b1;
         err_cause_d = err_set_cause_c;
         err_addr_d  = err_set_addr_c;
      end else if (err_clr_i) begin
         err_valid_d = 1'b0;
         err_cause_d = NONE;
         err_addr_d  = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         pwrite_q    <= 1'b0;
         psel_q      <= '0;
         penable_q   <= 1'b0;
         pready_q    <= 1'b0;
         prdata_q    <= '0;
         pslverr_q   <= 1'b0;
         err_valid_q <= 1'b0;
         err_cause_q <= NONE;
         err_addr_q  <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         pwrite_q    <= pwrite_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pready_q    <= pready_d;
         prdata_q    <= prdata_d;
         pslverr_q   <= pslverr_d;
         err_valid_q <= err_valid_d;
         err_cause_q <= err_cause_d;
         err_addr_q  <= err_addr_d;
      end
   end

   assign s_prdata_o  = prdata_q;
   assign s_pready_o  = pready_q;
   assign s_pslverr_o = pslverr_q;
   assign m_psel_o    = psel_q;
   assign m_penable_o = penable_q;
   assign m_pwrite_o  = pwrite_q;
   assign m_paddr_o   = paddr_q;
   assign m_pwdata_o  = pwdata_q;
   assign err_valid_o = err_valid_q;
   assign err_cause_o = err_cause_q;
   assign err_addr_o  = err_addr_q;

endmodule

// File: tb/tb_apb_rule_demux.sv
// Self-checking bench for apb_rule_demux: directed vector table, random transfers
// against an address-map reference model, and an asynchronous reset mid-access.
module tb_apb_rule_demux;

   localparam int unsigned NP = 4;
   localparam int unsigned TO = 8;
`ifdef APB_DEMUX_TIMEOUT_EN
   localparam bit ToEn = 1'b1;
`else
   localparam bit ToEn = 1'b0;
`endif

   logic              clk;
   logic              rst_n;
   logic              s_psel_i, s_penable_i, s_pwrite_i;
   logic [31:0]       s_paddr_i, s_pwdata_i;
   logic [31:0]       s_prdata_o;
   logic              s_pready_o, s_pslverr_o;
   logic [NP-1:0]     m_psel_o;
   logic              m_penable_o, m_pwrite_o;
   logic [31:0]       m_paddr_o, m_pwdata_o;
   logic [NP*32-1:0]  m_prdata_i;
   logic [NP-1:0]     m_pready_i, m_pslverr_i;
   logic              err_clr_i;
   logic              err_valid_o;
   logic [1:0]        err_cause_o;
   logic [31:0]       err_addr_o;

   apb_rule_demux #(
      .NrPorts       (NP),
      .AddrWidth     (32),
      .DataWidth     (32),
      .TimeoutCycles (TO)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .s_psel_i    (s_psel_i),
      .s_penable_i (s_penable_i),
      .s_pwrite_i  (s_pwrite_i),
      .s_paddr_i   (s_paddr_i),
      .s_pwdata_i  (s_pwdata_i),
      .s_prdata_o  (s_prdata_o),
      .s_pready_o  (s_pready_o),
      .s_pslverr_o (s_pslverr_o),
      .m_psel_o    (m_psel_o),
      .m_penable_o (m_penable_o),
      .m_pwrite_o  (m_pwrite_o),
      .m_paddr_o   (m_paddr_o),
      .m_pwdata_o  (m_pwdata_o),
      .m_prdata_i  (m_prdata_i),
      .m_pready_i  (m_pready_i),
      .m_pslverr_i (m_pslverr_i),
      .err_clr_i   (err_clr_i),
      .err_valid_o (err_valid_o),
      .err_cause_o (err_cause_o),
      .err_addr_o  (err_addr_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference address map: [base, last) per port, lowest index wins.
   logic [31:0] mbase [NP] = '{32'h0002_0000, 32'h0003_0000, 32'h0003_0100, 32'h0003_0000};
   logic [31:0] mlast [NP] = '{32'h0002_0100, 32'h0003_0100, 32'h0003_0200, 32'h0003_0400};

   // Subordinate models: ready after sub_ws access cycles.
   int          sub_ws    [NP];
   logic [31:0] sub_rdata [NP];
   bit          sub_err   [NP];
   int          acc_cnt;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)                       acc_cnt <= 0;
      else if (m_penable_o && |m_psel_o) acc_cnt <= acc_cnt + 1;
      else                              acc_cnt <= 0;
   end

   always_comb begin
      for (int p = 0; p < int'(NP); p++) begin
         m_pready_i[p]           = m_psel_o[p] && m_penable_o && (acc_cnt >= sub_ws[p]);
         m_pslverr_i[p]          = sub_err[p];
         m_prdata_i[p*32 +: 32]  = sub_rdata[p];
      end
   end

   // Model of the error register.
   bit          m_ev;
   logic [1:0]  m_ec;
   logic [31:0] m_ea;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic int port_of(input logic [31:0] a);
      for (int i = 0; i < int'(NP); i++)
         if ((a >= mbase[i]) && (a < mlast[i])) return i;
      return -1;
   endfunction

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         s_psel_i    = 1'b0;
         s_penable_i = 1'b0;
      end
   endtask

   // One upstream transfer; returns latency in edges after the trigger edge (0 = never).
   task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata, input bit clr,
                       output int lat, output logic [31:0] rdata, output bit serr,
                       output logic [NP-1:0] psel_seen, output bit proto_ok);
      @(negedge clk);
      s_psel_i = 1'b1; s_penable_i = 1'b0; s_pwrite_i = wr;
      s_paddr_i = addr; s_pwdata_i = wdata; err_clr_i = clr;
      lat = 0; rdata = '0; serr = 1'b0; psel_seen = '0; proto_ok = 1'b1;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         err_clr_i   = 1'b0;
         s_penable_i = 1'b1;
         psel_seen   = psel_seen | m_psel_o;
         if ((m_paddr_o !== addr) || (m_pwdata_o !== wdata) || (m_pwrite_o !== wr)) proto_ok = 1'b0;
         if (s_pready_o === 1'b1) begin
            lat = n; rdata = s_prdata_o; serr = s_pslverr_o;
            if ((m_psel_o !== '0) || (m_penable_o !== 1'b0)) proto_ok = 1'b0;
            break;
         end
         if (!$onehot(m_psel_o) || (m_penable_o !== (n >= 2))) proto_ok = 1'b0;
         if ((s_prdata_o !== '0) || (s_pslverr_o !== 1'b0)) proto_ok = 1'b0;
      end
   endtask

   task automatic run_one(input string tag, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input bit clr, input int elat, input logic [31:0] erd, input bit ese,
                          input logic [NP-1:0] epsel, input bit ev, input logic [1:0] ec, input logic [31:0] ea);
      int lat; logic [31:0] rd; bit se; logic [NP-1:0] ps; bit ok;
      xfer(wr, addr, wdata, clr, lat, rd, se, ps, ok);
      chk({tag, ".latency"},   32'(lat),         32'(elat));
      chk({tag, ".prdata"},    rd,               erd);
      chk({tag, ".pslverr"},   32'(se),          32'(ese));
      chk({tag, ".psel"},      32'(ps),          32'(epsel));
      chk({tag, ".protocol"},  32'(ok),          32'd1);
      chk({tag, ".err_valid"}, 32'(err_valid_o), 32'(ev));
      chk({tag, ".err_cause"}, 32'(err_cause_o), 32'(ec));
      chk({tag, ".err_addr"},  err_addr_o,       ea);
   endtask

   // Behavioural expectation for the current subordinate settings; advances the error model.
   task automatic model(input logic [31:0] addr, input bit clr, output int elat, output logic [31:0] erd,
                        output bit ese, output logic [NP-1:0] epsel);
      int p; bit ev; logic [1:0] ec;
      p = port_of(addr); ev = 1'b0; ec = 2'b00;
      if (p < 0) begin
         elat = 1; erd = '0; ese = 1'b1; epsel = '0; ev = 1'b1; ec = 2'b01;
      end else begin
         epsel = NP'(1 << p);
         if (ToEn && (sub_ws[p] >= int'(TO))) begin
            elat = 2 + int'(TO); erd = '0; ese = 1'b1; ev = 1'b1; ec = 2'b10;
         end else begin
            elat = 3 + sub_ws[p]; erd = sub_rdata[p]; ese = sub_err[p];
         end
      end
      if (ev && (!m_ev || clr)) begin
         m_ev = 1'b1; m_ec = ec; m_ea = addr;
      end else if (clr) begin
         m_ev = 1'b0; m_ec = 2'b00; m_ea = '0;
      end
   endtask

   typedef struct {
      bit          wr;
      logic [31:0] addr, wdata;
      int          port, ws;
      logic [31:0] srd;
      bit          serr, clr;
      int          elat;
      logic [31:0] erd;
      bit          ese;
      logic [3:0]  epsel;
      bit          ev;
      logic [1:0]  ec;
      logic [31:0] ea;
   } vec_t;

   function automatic vec_t mk(bit wr, logic [31:0] addr, logic [31:0] wdata, int port, int ws,
                               logic [31:0] srd, bit serr, bit clr, int elat, logic [31:0] erd,
                               bit ese, logic [3:0] epsel, bit ev, logic [1:0] ec, logic [31:0] ea);
      vec_t v;
      v.wr = wr; v.addr = addr; v.wdata = wdata; v.port = port; v.ws = ws; v.srd = srd;
      v.serr = serr; v.clr = clr; v.elat = elat; v.erd = erd; v.ese = ese; v.epsel = epsel;
      v.ev = ev; v.ec = ec; v.ea = ea;
      return v;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation still running at %0t", $time);
      $fatal(1, "bench watchdog expired");
   end

   initial begin
      vec_t vecs[$];
      int elat; logic [31:0] erd; bit ese; logic [NP-1:0] eps;
      logic [31:0] addr; bit clr; int sel; bit quiet;

      rst_n = 1'b0; s_psel_i = 1'b0; s_penable_i = 1'b0; s_pwrite_i = 1'b0;
      s_paddr_i = '0; s_pwdata_i = '0; err_clr_i = 1'b0;
      for (int p = 0; p < int'(NP); p++) begin sub_ws[p] = 0; sub_rdata[p] = '0; sub_err[p] = 1'b0; end
      m_ev = 1'b0; m_ec = 2'b00; m_ea = '0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("reset.pready",  32'({s_pready_o, s_pslverr_o, m_penable_o, m_pwrite_o}), 32'd0);
      chk("reset.psel",    32'(m_psel_o), 32'd0);
      chk("reset.paddr",   m_paddr_o | m_pwdata_o | s_prdata_o, 32'd0);
      chk("reset.err",     32'({err_valid_o, err_cause_o}) | err_addr_o, 32'd0);
      rst_n = 1'b1;

      // Directed vectors, back-to-back (no idle between transfers)
      vecs.push_back(mk(1, 32'h0003_0104, 32'hDEAD_BEEF, 2, 0, 32'h0,         0, 0, 3, 32'h0,         0, 4'b0100, 0, 2'b00, 32'h0));
      vecs.push_back(mk(0, 32'h0003_0010, 32'h0,         1, 3, 32'h1234_5678, 0, 0, 6, 32'h1234_5678, 0, 4'b0010, 0, 2'b00, 32'h0));
      vecs.push_back(mk(0, 32'h0004_0000, 32'h0,        -1, 0, 32'h0,         0, 0, 1, 32'h0,         1, 4'b0000, 1, 2'b01, 32'h0004_0000));
      vecs.push_back(mk(1, 32'h0003_0180, 32'h0000_1111, 2, 0, 32'hA5A5_0002, 1, 0, 3, 32'hA5A5_0002, 1, 4'b0100, 1, 2'b01, 32'h0004_0000));
      vecs.push_back(mk(1, 32'h0003_0200, 32'hCAFE_F00D, 3, 1, 32'h3333_3333, 0, 0, 4, 32'h3333_3333, 0, 4'b1000, 1, 2'b01, 32'h0004_0000));
      vecs.push_back(mk(0, 32'h0002_0040, 32'h0,         0, 0, 32'h0BAD_0000, 0, 0, 3, 32'h0BAD_0000, 0, 4'b0001, 1, 2'b01, 32'h0004_0000));
      vecs.push_back(mk(0, 32'h0003_00FF, 32'h0,         1, 2, 32'h1111_0000, 0, 0, 5, 32'h1111_0000, 0, 4'b0010, 1, 2'b01, 32'h0004_0000));
      vecs.push_back(mk(0, 32'h0003_0100, 32'h0,         2, 0, 32'h2222_0000, 0, 0, 3, 32'h2222_0000, 0, 4'b0100, 1, 2'b01, 32'h0004_0000));
      vecs.push_back(mk(0, 32'h0001_FFFC, 32'h0,        -1, 0, 32'h0,         0, 0, 1, 32'h0,         1, 4'b0000, 1, 2'b01, 32'h0004_0000));
      vecs.push_back(mk(0, 32'h0005_1000, 32'h0,        -1, 0, 32'h0,         0, 1, 1, 32'h0,         1, 4'b0000, 1, 2'b01, 32'h0005_1000));
      vecs.push_back(mk(0, 32'h0003_0004, 32'h0,         1, 0, 32'h4444_0000, 0, 1, 3, 32'h4444_0000, 0, 4'b0010, 0, 2'b00, 32'h0));
`ifdef APB_DEMUX_TIMEOUT_EN
      vecs.push_back(mk(0, 32'h0003_0020, 32'h0,         1, 7, 32'h7777_7777, 0, 0, 10, 32'h7777_7777, 0, 4'b0010, 0, 2'b00, 32'h0));
      vecs.push_back(mk(0, 32'h0004_0000, 32'h0,        -1, 0, 32'h0,         0, 0, 1,  32'h0,         1, 4'b0000, 1, 2'b01, 32'h0004_0000));
      vecs.push_back(mk(0, 32'h0003_0030, 32'h0,         1, 1000, 32'h9999_9999, 0, 0, 10, 32'h0,      1, 4'b0010, 1, 2'b01, 32'h0004_0000));
      vecs.push_back(mk(0, 32'h0003_0034, 32'h0,         1, 1000, 32'h9999_9999, 0, 1, 10, 32'h0,      1, 4'b0010, 1, 2'b10, 32'h0003_0034));
      vecs.push_back(mk(1, 32'h0003_0038, 32'h1,         1, 8, 32'h8888_8888, 0, 0, 10, 32'h0,         1, 4'b0010, 1, 2'b10, 32'h0003_0034));
`else
      vecs.push_back(mk(0, 32'h0003_0020, 32'h0,         1, 20, 32'h7777_7777, 0, 0, 23, 32'h7777_7777, 0, 4'b0010, 0, 2'b00, 32'h0));
      vecs.push_back(mk(0, 32'h0003_0024, 32'h0,         1, 9, 32'h6666_6666, 1, 0, 12, 32'h6666_6666, 1, 4'b0010, 0, 2'b00, 32'h0));
`endif
      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].port >= 0) begin
            sub_ws[vecs[i].port]    = vecs[i].ws;
            sub_rdata[vecs[i].port] = vecs[i].srd;
            sub_err[vecs[i].port]   = vecs[i].serr;
         end
         run_one($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].clr,
                 vecs[i].elat, vecs[i].erd, vecs[i].ese, vecs[i].epsel, vecs[i].ev, vecs[i].ec, vecs[i].ea);
         m_ev = vecs[i].ev; m_ec = vecs[i].ec; m_ea = vecs[i].ea;
      end
      idle_cycles(2);

      // Randomized transfers against the reference model
      for (int k = 0; k < 200; k++) begin
         for (int p = 0; p < int'(NP); p++) begin
            sub_ws[p] = int'($urandom_range(0, 9)); sub_rdata[p] = $urandom; sub_err[p] = 1'($urandom_range(0, 1));
         end
         sel = int'($urandom_range(0, 3));
         case (sel)
            0:       addr = 32'h0001_FF80 + $urandom_range(0, 32'h1FF);
            1:       addr = 32'h0002_FF80 + $urandom_range(0, 32'h4FF);
            2:       addr = $urandom;
            default: addr = 32'h0005_0000 + $urandom_range(0, 32'h1FFF);
         endcase
         clr = ($urandom_range(0, 7) == 0);
         model(addr, clr, elat, erd, ese, eps);
         run_one($sformatf("rnd%0d", k), 1'($urandom_range(0, 1)), addr, $urandom, clr,
                 elat, erd, ese, eps, m_ev, m_ec, m_ea);
         if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 2)));
      end

      // Asynchronous reset in the middle of an access phase
      model(32'h0006_0000, 1'b0, elat, erd, ese, eps);
      run_one("rst.pre_miss", 1'b0, 32'h0006_0000, 32'h0, 1'b0, elat, erd, ese, eps, m_ev, m_ec, m_ea);
      sub_ws[1] = 1000;
      @(negedge clk);
      s_psel_i = 1'b1; s_penable_i = 1'b0; s_pwrite_i = 1'b1;
      s_paddr_i = 32'h0003_0044; s_pwdata_i = 32'h5555_AAAA;
      @(negedge clk); s_penable_i = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst.in_access", 32'({m_psel_o, m_penable_o}), 32'({4'b0010, 1'b1}));
      #2 rst_n = 1'b0;
      #1;
      chk("rst.async_sel",  32'({m_psel_o, m_penable_o, m_pwrite_o}), 32'd0);
      chk("rst.async_addr", m_paddr_o | m_pwdata_o, 32'd0);
      chk("rst.async_err",  32'({err_valid_o, err_cause_o}) | err_addr_o, 32'd0);
      chk("rst.async_resp", 32'({s_pready_o, s_pslverr_o}) | s_prdata_o, 32'd0);
      @(negedge clk);
      s_psel_i = 1'b0; s_penable_i = 1'b0; sub_ws[1] = 0; sub_rdata[1] = 32'hFEED_0001; sub_err[1] = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      m_ev = 1'b0; m_ec = 2'b00; m_ea = '0;
      quiet = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if ((s_pready_o !== 1'b0) || (m_psel_o !== '0)) quiet = 1'b0;
      end
      chk("rst.no_late_resp", 32'(quiet), 32'd1);
      run_one("rst.after", 1'b0, 32'h0003_0008, 32'h0, 1'b0, 3, 32'hFEED_0001, 1'b0, 4'b0010, 1'b0, 2'b00, 32'h0);
      idle_cycles(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
